// File: rtl/uart_psram_cmd_pkg.sv
// rtl/uart_psram_cmd_pkg.sv - shared opcodes, state encoding and default widths for uart_psram_cmd
package psram_uart_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] ACK_BYTE = 8'h4B;

    localparam int DEF_ADDR_W = 23;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_ISSUE,
        ST_WAIT_RD,
        ST_TX_HI,
        ST_TX_LO,
        ST_ACK
    } state_t;

endpackage

// File: rtl/uart_psram_cmd_if.sv
// rtl/uart_psram_cmd_if.sv - UART/PSRAM/probe bundle; UART_PSRAM_CMD_DEBUG_ADDR_EN adds debug_address
interface uart_psram_cmd_if
    import psram_uart_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              mem_cmd_valid;
    logic              mem_cmd_write;
    logic              mem_cmd_ready;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [DATA_W-1:0] data_out;
    logic              debug;
    logic              busy;
    logic              err;
`ifdef UART_PSRAM_CMD_DEBUG_ADDR_EN
    logic [ADDR_W-1:0] debug_address;

    modport master (
        input  rx_data, rx_valid, tx_ready, mem_cmd_ready, rd_data, rd_valid,
        output tx_data, tx_valid, mem_cmd_valid, mem_cmd_write, address, wr_data,
        output data_out, debug, busy, err, debug_address
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, mem_cmd_ready, rd_data, rd_valid,
        input  tx_data, tx_valid, mem_cmd_valid, mem_cmd_write, address, wr_data,
        input  data_out, debug, busy, err, debug_address
    );
`else
    modport master (
        input  rx_data, rx_valid, tx_ready, mem_cmd_ready, rd_data, rd_valid,
        output tx_data, tx_valid, mem_cmd_valid, mem_cmd_write, address, wr_data,
        output data_out, debug, busy, err
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, mem_cmd_ready, rd_data, rd_valid,
        input  tx_data, tx_valid, mem_cmd_valid, mem_cmd_write, address, wr_data,
        input  data_out, debug, busy, err
    );
`endif

endinterface

// File: rtl/uart_psram_cmd_frame_timeout.sv
// rtl/uart_psram_cmd_frame_timeout.sv - inter-byte idle counter with clear/enable and expire pulse
module frame_timeout #(
    parameter int TIMEOUT_CYC = 2700000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] cnt;

    // A byte arriving in the expiry cycle suppresses the expiry.
    assign expire = en && !clr && (cnt == CNT_W'(TIMEOUT_CYC - 1));

    // Count idle cycles while a frame is being assembled; restart on every byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || !en || expire) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_psram_cmd.sv
// rtl/uart_psram_cmd.sv - UART framed command parser issuing PSRAM word reads/writes; option UART_PSRAM_CMD_DEBUG_ADDR_EN
module uart_psram_cmd
    import psram_uart_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = 2700000
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    uart_psram_cmd_if.master  bus
);

    state_t            state;
    state_t            state_n;
    logic              op_write;
    logic              op_write_n;
    logic [1:0]        byte_cnt;
    logic [1:0]        byte_cnt_n;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wr_data_r;
    logic [DATA_W-1:0] data_out_r;
    logic              err_r;
    logic              err_n;
    logic              debug_r;
    logic              debug_n;
    logic              shift_addr;
    logic              shift_data;
    logic              load_rd;
    logic              tmo_en;
    logic              tmo_expire;

    // Idle-timeout only guards the partially received frame.
    assign tmo_en = (state == ST_ADDR) || (state == ST_DATA);

    frame_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk    (sys_clk),
        .rst_n  (sys_rst_n),
        .clr    (bus.rx_valid),
        .en     (tmo_en),
        .expire (tmo_expire)
    );

    // State, frame fields and one-cycle status pulses.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= ST_IDLE;
            op_write   <= 1'b0;
            byte_cnt   <= 2'd0;
            addr_r     <= '0;
            wr_data_r  <= '0;
            data_out_r <= '0;
            err_r      <= 1'b0;
            debug_r    <= 1'b0;
        end else begin
            state    <= state_n;
            op_write <= op_write_n;
            byte_cnt <= byte_cnt_n;
            err_r    <= err_n;
            debug_r  <= debug_n;
            if (shift_addr) begin
                addr_r <= ADDR_W'({addr_r, bus.rx_data});
            end
            if (shift_data) begin
                wr_data_r <= DATA_W'({wr_data_r, bus.rx_data});
            end
            if (load_rd) begin
                data_out_r <= bus.rd_data;
            end
        end
    end

    // Next-state and control decode for the frame parser.
    always_comb begin
        state_n    = state;
        op_write_n = op_write;
        byte_cnt_n = byte_cnt;
        err_n      = 1'b0;
        debug_n    = 1'b0;
        shift_addr = 1'b0;
        shift_data = 1'b0;
        load_rd    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == OP_WRITE || bus.rx_data == OP_READ) begin
                        op_write_n = (bus.rx_data == OP_WRITE);
                        byte_cnt_n = 2'd0;
                        state_n    = ST_ADDR;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                if (bus.rx_valid) begin
                    shift_addr = 1'b1;
                    if (byte_cnt == 2'd2) begin
                        byte_cnt_n = 2'd0;
                        state_n    = op_write ? ST_DATA : ST_ISSUE;
                    end else begin
                        byte_cnt_n = byte_cnt + 2'd1;
                    end
                end else if (tmo_expire) begin
                    err_n   = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (bus.rx_valid) begin
                    shift_data = 1'b1;
                    if (byte_cnt == 2'd1) begin
                        byte_cnt_n = 2'd0;
                        state_n    = ST_ISSUE;
                    end else begin
                        byte_cnt_n = byte_cnt + 2'd1;
                    end
                end else if (tmo_expire) begin
                    err_n   = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                err_n = bus.rx_valid;
                if (bus.mem_cmd_ready) begin
                    state_n = op_write ? ST_ACK : ST_WAIT_RD;
                end
            end
            ST_WAIT_RD: begin
                err_n = bus.rx_valid;
                if (bus.rd_valid) begin
                    load_rd = 1'b1;
                    state_n = ST_TX_HI;
                end
            end
            ST_TX_HI: begin
                err_n = bus.rx_valid;
                if (bus.tx_ready) begin
                    state_n = ST_TX_LO;
                end
            end
            ST_TX_LO: begin
                err_n = bus.rx_valid;
                if (bus.tx_ready) begin
                    debug_n = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_ACK: begin
                err_n = bus.rx_valid;
                if (bus.tx_ready) begin
                    debug_n = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Transmit byte selection; zero whenever nothing is being sent.
    always_comb begin
        bus.tx_data = 8'h00;
        case (state)
            ST_TX_HI: bus.tx_data = data_out_r[DATA_W-1 -: 8];
            ST_TX_LO: bus.tx_data = data_out_r[7:0];
            ST_ACK:   bus.tx_data = ACK_BYTE;
            default:  bus.tx_data = 8'h00;
        endcase
    end

    assign bus.tx_valid      = (state == ST_TX_HI) || (state == ST_TX_LO) || (state == ST_ACK);
    assign bus.mem_cmd_valid = (state == ST_ISSUE);
    assign bus.mem_cmd_write = (state == ST_ISSUE) && op_write;
    assign bus.address       = addr_r;
    assign bus.wr_data       = wr_data_r;
    assign bus.data_out      = data_out_r;
    assign bus.debug         = debug_r;
    assign bus.busy          = (state != ST_IDLE);
    assign bus.err           = err_r;

`ifdef UART_PSRAM_CMD_DEBUG_ADDR_EN
    logic [ADDR_W-1:0] debug_addr_r;

    // Capture the address of each completed transaction for the analyzer.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            debug_addr_r <= '0;
        end else if (debug_n) begin
            debug_addr_r <= addr_r;
        end
    end

    assign bus.debug_address = debug_addr_r;
`endif

endmodule

// File: doc/uart_psram_cmd.md
Name: uart_psram_cmd

Overview:
UART-to-PSRAM command parser feeding the PSRAM controller and the on-chip logic-analyzer probe set. It assembles framed byte commands from the UART receiver and issues single-word PSRAM read/write requests. It returns read data or a write acknowledge over the UART transmitter. It drives address, data_out and the debug strobe captured by the analyzer.

Parameters:
- ADDR_W, 23, PSRAM word address width.
- DATA_W, 16, PSRAM word width (fixed at 2 bytes on the wire).
- TIMEOUT_CYC, 2700000, inter-byte timeout in sys_clk cycles (100 ms at 27 MHz).

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle pulse per received byte.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  transmit request; held until tx_ready.
- tx_ready  in  1  transmitter accepts tx_data when tx_valid&tx_ready.
- mem_cmd_valid  out  1  PSRAM request; held until mem_cmd_ready.
- mem_cmd_write  out  1  1=write, 0=read; stable while mem_cmd_valid.
- mem_cmd_ready  in  1  controller accepts the request.
- address  out  ADDR_W  request address; stable from ISSUE until next frame.
- wr_data  out  DATA_W  write data.
- rd_data  in  DATA_W  PSRAM read data.
- rd_valid  in  1  one-cycle pulse; rd_data valid.
- data_out  out  DATA_W  last read word (registered).
- debug  out  1  one-cycle pulse per completed transaction.
- busy  out  1  high in any state other than IDLE.
- err  out  1  one-cycle pulse on a protocol error.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- Frames, MSB first:
  - Write: 0x57, A2, A1, A0, D1, D0.
  - Read: 0x52, A2, A1, A0.
  - address = {A2,A1,A0}[ADDR_W-1:0]; bit 23 is ignored.
- States:
  - IDLE: on rx_valid, 0x57 or 0x52 latches the opcode and goes to ADDR (byte count 0). Any other byte pulses err and stays in IDLE.
  - ADDR: shifts 3 bytes into address. After the 3rd byte, write goes to DATA, read goes to ISSUE.
  - DATA: shifts 2 bytes into wr_data, then goes to ISSUE.
  - ISSUE: mem_cmd_valid=1. On mem_cmd_ready: write goes to ACK, read goes to WAIT_RD. mem_cmd_valid drops the cycle after the handshake.
  - WAIT_RD: on rd_valid, data_out<=rd_data and go to TX_HI.
  - TX_HI: tx_data=data_out[15:8]; on handshake go to TX_LO.
  - TX_LO: tx_data=data_out[7:0]; on handshake go to IDLE.
  - ACK: tx_data=0x4B; on handshake go to IDLE.
- debug pulses in the cycle after the final TX handshake: TX_LO for reads, ACK for writes.
- Timeout: only in ADDR/DATA. The counter clears on each rx_valid. At TIMEOUT_CYC-1 with no byte: pulse err, go to IDLE, discard the partial frame.
- rx_valid in ISSUE/WAIT_RD/TX_*/ACK: byte dropped, err pulsed, state unaffected.
- rx_valid in the same cycle as the timeout expiry: the byte wins, counter clears, no err.
- rd_valid outside WAIT_RD is ignored.
- tx_valid and mem_cmd_valid never deassert before their handshake.
- Reset mid-operation aborts immediately to IDLE with outputs 0. Any in-flight PSRAM request is the controller's concern.

Optional Feature:
UART_PSRAM_CMD_DEBUG_ADDR_EN:
- Defined: adds output debug_address (ADDR_W). It is loaded with address on each debug pulse, resets to 0, and holds the last completed transaction address for analyzer probing.
- Undefined: port and register absent; no other behaviour change.

Decomposition:
- Package psram_uart_pkg:
  - OP_WRITE=8'h57, OP_READ=8'h52, ACK_BYTE=8'h4B.
  - State enum typedef.
  - Default ADDR_W/DATA_W localparams.
- One sub-module, frame_timeout: a counter with clear/enable inputs and an expire pulse, parameterised by TIMEOUT_CYC.

Test Plan:
- Write: send 57 00 12 34 AB CD, mem_cmd_ready=1 -> one mem_cmd_valid with write=1, address=0x001234, wr_data=0xABCD; tx 0x4B; one debug pulse.
- Read: send 52 7F FF FF, rd_valid 5 cycles after the handshake with rd_data=0xBEEF -> address=0x7FFFFF (bit 23 dropped); data_out=0xBEEF; tx BE then EF; one debug pulse.
- Backpressure: hold mem_cmd_ready=0 for 20 cycles and tx_ready=0 for 10 -> valids stay high with stable address/data; exactly one handshake each.
- Bad opcode/extra byte: send 0x00 -> err pulse, busy stays 0. Send 0x41 during WAIT_RD -> err pulse, the read still completes correctly.
- Timeout (TIMEOUT_CYC=100 in sim): send 57 00 then idle 100 cycles -> err pulse, busy=0. A following valid frame executes normally.
- Reset mid-frame: assert sys_rst_n=0 during DATA -> all outputs 0 asynchronously; after release, a fresh read frame works.
